// File: rtl/c66x_enable_ctrl_if.sv
// Signal bundle between the enable supervisor and its surroundings:
// run/clear requests and the sequencer state code in, enable and status out.
interface c66x_enable_ctrl_if;
  logic       run_req;
  logic       clear_fault;
  logic [3:0] seq_state;
  logic       enable;
  logic       fault;
  logic [1:0] retry_count;
  logic [2:0] ctrl_state;

  modport master (
    output run_req,
    output clear_fault,
    output seq_state,
    input  enable,
    input  fault,
    input  retry_count,
    input  ctrl_state
  );

  modport slave (
    input  run_req,
    input  clear_fault,
    input  seq_state,
    output enable,
    output fault,
    output retry_count,
    output ctrl_state
  );
endinterface

// File: rtl/c66x_enable_ctrl.sv
// Supervisor for the C66x power-sequencer enable: power-on hold-off, synchronised run
// request, start/run failure detection with back-off retries and a latched lockout.
module c66x_enable_ctrl #(
  parameter int TICK_BITS     = 13,
  parameter int POWERON_TICKS = 4,
  parameter int START_TICKS   = 255,
  parameter int BACKOFF_TICKS = 16,
  parameter int STABLE_TICKS  = 32,
  parameter int MAX_RETRIES   = 3
) (
  input  logic              sysclk,
  input  logic              reset_INV,
  c66x_enable_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_POR_WAIT = 3'd0,
    ST_IDLE     = 3'd1,
    ST_STARTING = 3'd2,
    ST_RUNNING  = 3'd3,
    ST_STOPPING = 3'd4,
    ST_BACKOFF  = 3'd5,
    ST_LOCKOUT  = 3'd6,
    ST_ILLEGAL  = 3'd7
  } state_e;

  localparam logic [7:0] PON_T     = 8'(POWERON_TICKS);
  localparam logic [7:0] START_T   = 8'(START_TICKS);
  localparam logic [7:0] BACKOFF_T = 8'(BACKOFF_TICKS);
  localparam logic [7:0] STABLE_T  = 8'(STABLE_TICKS);
  localparam logic [1:0] MAX_R     = 2'(MAX_RETRIES);

  logic [TICK_BITS-1:0] prescaler_q, prescaler_d;
  logic                 run_meta_q, run_s_q;
  state_e               state_q, state_d;
  logic [7:0]           timer_q, timer_d;
  logic                 enable_q, enable_d;
  logic                 fault_q, fault_d;
  logic [1:0]           retry_q, retry_d;
  logic                 stable_done_q, stable_done_d;

  logic       tick;
  logic       seq_off, seq_on, seq_shut;
  logic       fail;
  logic [2:0] retry_inc;

  assign tick      = &prescaler_q;
  assign seq_off   = (bus.seq_state == 4'd0);
  assign seq_on    = (bus.seq_state == 4'd9);
  assign seq_shut  = (bus.seq_state >= 4'd10);
  assign retry_inc = {1'b0, retry_q} + 3'd1;

  always_comb begin
    prescaler_d = prescaler_q + {{(TICK_BITS-1){1'b0}}, 1'b1};
  end

  // Next-state logic; 'fail' folds the shared start/run failure transition.
  always_comb begin
    state_d       = state_q;
    retry_d       = retry_q;
    stable_done_d = stable_done_q;
    fail          = 1'b0;

    case (state_q)
      ST_POR_WAIT: begin
        if (timer_q >= PON_T) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (run_s_q && seq_off) state_d = ST_STARTING;
      end
      ST_STARTING: begin
        if (!run_s_q)                           state_d = ST_STOPPING;
        else if (seq_shut || timer_q == START_T) fail   = 1'b1;
        else if (seq_on)                        state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (!run_s_q)     state_d = ST_STOPPING;
        else if (!seq_on) fail    = 1'b1;
        else if (timer_q == STABLE_T && !stable_done_q) begin
          retry_d       = 2'd0;
          stable_done_d = 1'b1;
        end
      end
      ST_STOPPING: begin
        if (seq_off) begin
          state_d = ST_IDLE;
          retry_d = 2'd0;
        end
      end
      ST_BACKOFF: begin
        if (seq_off && timer_q >= BACKOFF_T) state_d = run_s_q ? ST_STARTING : ST_IDLE;
      end
      ST_LOCKOUT: begin
        // run_s is deliberately ignored; only an explicit clear with the sequencer off exits
        if (bus.clear_fault && seq_off) begin
          state_d = ST_IDLE;
          retry_d = 2'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fail) begin
      if (retry_inc == {1'b0, MAX_R}) begin
        state_d = ST_LOCKOUT;
        retry_d = MAX_R;
      end else begin
        state_d = ST_BACKOFF;
        retry_d = retry_inc[1:0];
      end
    end

    if (state_d != state_q) stable_done_d = 1'b0;
  end

  // Outputs are registered from the next state so a failure drops enable on the same edge.
  always_comb begin
    enable_d = (state_d == ST_STARTING) || (state_d == ST_RUNNING);
    fault_d  = (state_d == ST_LOCKOUT);
    timer_d  = timer_q;
    if (state_d != state_q)        timer_d = 8'd0;
    else if (tick && timer_q != 8'hFF) timer_d = timer_q + 8'd1;
  end

  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      prescaler_q   <= '0;
      run_meta_q    <= 1'b0;
      run_s_q       <= 1'b0;
      state_q       <= ST_POR_WAIT;
      timer_q       <= 8'd0;
      enable_q      <= 1'b0;
      fault_q       <= 1'b0;
      retry_q       <= 2'd0;
      stable_done_q <= 1'b0;
    end else begin
      prescaler_q   <= prescaler_d;
      run_meta_q    <= bus.run_req;
      run_s_q       <= run_meta_q;
      state_q       <= state_d;
      timer_q       <= timer_d;
      enable_q      <= enable_d;
      fault_q       <= fault_d;
      retry_q       <= retry_d;
      stable_done_q <= stable_done_d;
    end
  end

  assign bus.enable      = enable_q;
  assign bus.fault       = fault_q;
  assign bus.retry_count = retry_q;
  assign bus.ctrl_state  = state_q;

  a_enable_matches_state : assert property (@(posedge sysclk) disable iff (!reset_INV)
    enable_q == ((state_q == ST_STARTING) || (state_q == ST_RUNNING)));
  a_fault_only_lockout : assert property (@(posedge sysclk) disable iff (!reset_INV)
    fault_q == (state_q == ST_LOCKOUT));
  a_retry_bounded : assert property (@(posedge sysclk) disable iff (!reset_INV)
    retry_q <= MAX_R);
  a_no_illegal_state : assert property (@(posedge sysclk) disable iff (!reset_INV)
    state_q != ST_ILLEGAL);

endmodule

// File: tb/tb_c66x_enable_ctrl.sv
// Self-checking bench for c66x_enable_ctrl: every ctrl_state transition is matched
// against a queue of expected transitions pushed when stimulus is applied.
module tb_c66x_enable_ctrl;

  logic sysclk = 1'b0;
  logic reset_INV;

  c66x_enable_ctrl_if dut_if ();

  c66x_enable_ctrl #(
    .TICK_BITS    (4),
    .POWERON_TICKS(4),
    .START_TICKS  (20),
    .BACKOFF_TICKS(3),
    .STABLE_TICKS (5),
    .MAX_RETRIES  (3)
  ) dut (
    .sysclk   (sysclk),
    .reset_INV(reset_INV),
    .bus      (dut_if)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic       en;
    logic       flt;
    logic [1:0] rc;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  logic [2:0] last_state = 3'd0;

  task automatic expect_tr(input string n, input logic [2:0] st, input logic en,
                           input logic flt, input logic [1:0] rc);
    exp_t e;
    e.name = n; e.st = st; e.en = en; e.flt = flt; e.rc = rc;
    sb.push_back(e);
  endtask

  // Advance one cycle, sample on the falling edge, and score any state transition.
  task automatic step();
    exp_t e;
    @(negedge sysclk);
    if (dut_if.ctrl_state !== last_state) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: state went %0d -> %0d with no transition expected",
                 last_state, dut_if.ctrl_state);
      end else begin
        e = sb.pop_front();
        if ({dut_if.ctrl_state, dut_if.enable, dut_if.fault, dut_if.retry_count} !==
            {e.st, e.en, e.flt, e.rc}) begin
          failures++;
          $display("FAIL sb_%s: got st=%0d en=%0d flt=%0d rc=%0d, want st=%0d en=%0d flt=%0d rc=%0d",
                   e.name, dut_if.ctrl_state, dut_if.enable, dut_if.fault, dut_if.retry_count,
                   e.st, e.en, e.flt, e.rc);
        end
      end
      last_state = dut_if.ctrl_state;
    end
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, output int cycles);
    cycles = 0;
    while (dut_if.ctrl_state !== target && cycles < budget) begin
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    int cyc;
    reset_INV = 1'b0;
    dut_if.run_req = 1'b1;
    dut_if.clear_fault = 1'b0;
    dut_if.seq_state = 4'd0;
    repeat (3) step();
    checks++;
    if ({dut_if.enable, dut_if.fault, dut_if.retry_count, dut_if.ctrl_state} !== 7'd0) begin
      failures++;
      $display("FAIL reset_state: got en=%0d flt=%0d rc=%0d st=%0d, want all 0",
               dut_if.enable, dut_if.fault, dut_if.retry_count, dut_if.ctrl_state);
    end
    expect_tr("por_to_idle", 3'd1, 1'b0, 1'b0, 2'd0);
    expect_tr("idle_to_start", 3'd2, 1'b1, 1'b0, 2'd0);
    reset_INV = 1'b1;
    cyc = 0;
    while (dut_if.enable !== 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
    checks++;
    if (cyc < 64 || cyc > 68 || dut_if.ctrl_state !== 3'd2) begin
      failures++;
      $display("FAIL poweron_delay: enable rose after %0d cycles in state %0d, want 64..68 cycles in state 2",
               cyc, dut_if.ctrl_state);
    end
    dut_if.seq_state = 4'd9;
    expect_tr("start_to_run", 3'd3, 1'b1, 1'b0, 2'd0);
    wait_state(3'd3, 5, cyc);
    checks++;
    if (dut_if.ctrl_state !== 3'd3) begin
      failures++;
      $display("FAIL reach_running: got st=%0d, want 3", dut_if.ctrl_state);
    end
  endtask

  task automatic test_stop();
    int cyc;
    expect_tr("run_to_stop", 3'd4, 1'b0, 1'b0, 2'd0);
    dut_if.run_req = 1'b0;
    step();
    step();
    checks++;
    if (dut_if.enable !== 1'b1) begin
      failures++;
      $display("FAIL stop_latency_early: got en=%0d after 2 cycles, want 1", dut_if.enable);
    end
    step();
    checks++;
    if (dut_if.enable !== 1'b0 || dut_if.ctrl_state !== 3'd4) begin
      failures++;
      $display("FAIL stop_latency: got en=%0d st=%0d after 3 cycles, want en=0 st=4",
               dut_if.enable, dut_if.ctrl_state);
    end
    dut_if.seq_state = 4'd0;
    expect_tr("stop_to_idle", 3'd1, 1'b0, 1'b0, 2'd0);
    wait_state(3'd1, 5, cyc);
    checks++;
    if (dut_if.ctrl_state !== 3'd1 || dut_if.retry_count !== 2'd0) begin
      failures++;
      $display("FAIL stop_idle: got st=%0d rc=%0d, want st=1 rc=0", dut_if.ctrl_state, dut_if.retry_count);
    end
  endtask

  task automatic test_start_fail();
    int cyc;
    expect_tr("idle_to_start", 3'd2, 1'b1, 1'b0, 2'd0);
    dut_if.run_req = 1'b1;
    wait_state(3'd2, 10, cyc);
    dut_if.seq_state = 4'd11;
    expect_tr("shut_fail", 3'd5, 1'b0, 1'b0, 2'd1);
    step();
    checks++;
    if (dut_if.enable !== 1'b0 || dut_if.retry_count !== 2'd1 || dut_if.ctrl_state !== 3'd5) begin
      failures++;
      $display("FAIL start_fail: got en=%0d rc=%0d st=%0d, want en=0 rc=1 st=5",
               dut_if.enable, dut_if.retry_count, dut_if.ctrl_state);
    end
    dut_if.seq_state = 4'd0;
    expect_tr("backoff_retry", 3'd2, 1'b1, 1'b0, 2'd1);
    wait_state(3'd2, 100, cyc);
    checks++;
    if (dut_if.ctrl_state !== 3'd2 || cyc < 32) begin
      failures++;
      $display("FAIL backoff_time: got st=%0d after %0d cycles, want st=2 after >=32", dut_if.ctrl_state, cyc);
    end
  endtask

  task automatic test_lockout();
    int cyc;
    int en_seen;
    dut_if.seq_state = 4'd11;
    expect_tr("second_fail", 3'd5, 1'b0, 1'b0, 2'd2);
    wait_state(3'd5, 4, cyc);
    dut_if.seq_state = 4'd0;
    expect_tr("backoff_retry2", 3'd2, 1'b1, 1'b0, 2'd2);
    wait_state(3'd2, 100, cyc);
    dut_if.seq_state = 4'd12;
    expect_tr("to_lockout", 3'd6, 1'b0, 1'b1, 2'd3);
    step();
    checks++;
    if (dut_if.ctrl_state !== 3'd6 || dut_if.fault !== 1'b1 || dut_if.retry_count !== 2'd3 ||
        dut_if.enable !== 1'b0) begin
      failures++;
      $display("FAIL lockout_entry: got st=%0d flt=%0d rc=%0d en=%0d, want st=6 flt=1 rc=3 en=0",
               dut_if.ctrl_state, dut_if.fault, dut_if.retry_count, dut_if.enable);
    end
    dut_if.seq_state = 4'd0;
    en_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (dut_if.enable === 1'b1) en_seen++;
    end
    checks++;
    if (en_seen != 0 || dut_if.ctrl_state !== 3'd6) begin
      failures++;
      $display("FAIL lockout_hold: got %0d enable cycles st=%0d, want 0 cycles st=6", en_seen, dut_if.ctrl_state);
    end
    dut_if.run_req = 1'b0;
    repeat (3) step();
    dut_if.seq_state = 4'd12;
    dut_if.clear_fault = 1'b1;
    step();
    dut_if.clear_fault = 1'b0;
    step();
    checks++;
    if (dut_if.ctrl_state !== 3'd6) begin
      failures++;
      $display("FAIL clear_while_shut: got st=%0d, want 6", dut_if.ctrl_state);
    end
    dut_if.seq_state = 4'd0;
    repeat (3) step();
    checks++;
    if (dut_if.ctrl_state !== 3'd6) begin
      failures++;
      $display("FAIL clear_not_remembered: got st=%0d, want 6", dut_if.ctrl_state);
    end
    expect_tr("clear_to_idle", 3'd1, 1'b0, 1'b0, 2'd0);
    dut_if.clear_fault = 1'b1;
    step();
    dut_if.clear_fault = 1'b0;
    checks++;
    if (dut_if.ctrl_state !== 3'd1 || dut_if.fault !== 1'b0 || dut_if.retry_count !== 2'd0) begin
      failures++;
      $display("FAIL clear_exit: got st=%0d flt=%0d rc=%0d, want st=1 flt=0 rc=0",
               dut_if.ctrl_state, dut_if.fault, dut_if.retry_count);
    end
    dut_if.clear_fault = 1'b1;
    step();
    dut_if.clear_fault = 1'b0;
    step();
    checks++;
    if (dut_if.ctrl_state !== 3'd1 || dut_if.fault !== 1'b0) begin
      failures++;
      $display("FAIL clear_outside_lockout: got st=%0d flt=%0d, want st=1 flt=0", dut_if.ctrl_state, dut_if.fault);
    end
  endtask

  task automatic test_timeout_and_stable();
    int cyc;
    expect_tr("idle_to_start", 3'd2, 1'b1, 1'b0, 2'd0);
    dut_if.run_req = 1'b1;
    wait_state(3'd2, 10, cyc);
    expect_tr("start_timeout", 3'd5, 1'b0, 1'b0, 2'd1);
    wait_state(3'd5, 400, cyc);
    checks++;
    if (dut_if.ctrl_state !== 3'd5 || dut_if.retry_count !== 2'd1 || cyc < 300 || cyc > 330) begin
      failures++;
      $display("FAIL start_timeout: got st=%0d rc=%0d after %0d cycles, want st=5 rc=1 after 300..330",
               dut_if.ctrl_state, dut_if.retry_count, cyc);
    end
    expect_tr("timeout_retry", 3'd2, 1'b1, 1'b0, 2'd1);
    wait_state(3'd2, 100, cyc);
    dut_if.seq_state = 4'd9;
    expect_tr("retry_to_run", 3'd3, 1'b1, 1'b0, 2'd1);
    wait_state(3'd3, 5, cyc);
    cyc = 0;
    while (dut_if.retry_count !== 2'd0 && cyc < 200) begin
      step();
      cyc++;
    end
    checks++;
    if (dut_if.retry_count !== 2'd0 || dut_if.ctrl_state !== 3'd3 || cyc < 64 || cyc > 90) begin
      failures++;
      $display("FAIL stable_clear: got rc=%0d st=%0d after %0d cycles, want rc=0 st=3 after 64..90",
               dut_if.retry_count, dut_if.ctrl_state, cyc);
    end
    dut_if.seq_state = 4'd0;
    expect_tr("run_dropout", 3'd5, 1'b0, 1'b0, 2'd1);
    step();
    checks++;
    if (dut_if.ctrl_state !== 3'd5 || dut_if.enable !== 1'b0 || dut_if.retry_count !== 2'd1) begin
      failures++;
      $display("FAIL run_dropout: got st=%0d en=%0d rc=%0d, want st=5 en=0 rc=1",
               dut_if.ctrl_state, dut_if.enable, dut_if.retry_count);
    end
    expect_tr("dropout_retry", 3'd2, 1'b1, 1'b0, 2'd1);
    wait_state(3'd2, 100, cyc);
    dut_if.seq_state = 4'd9;
    expect_tr("retry_to_run2", 3'd3, 1'b1, 1'b0, 2'd1);
    wait_state(3'd3, 5, cyc);
  endtask

  task automatic test_async_reset();
    expect_tr("async_reset", 3'd0, 1'b0, 1'b0, 2'd0);
    #2;
    reset_INV = 1'b0;
    #1;
    checks++;
    if ({dut_if.enable, dut_if.fault, dut_if.retry_count, dut_if.ctrl_state} !== 7'd0) begin
      failures++;
      $display("FAIL async_reset: got en=%0d flt=%0d rc=%0d st=%0d before next edge, want all 0",
               dut_if.enable, dut_if.fault, dut_if.retry_count, dut_if.ctrl_state);
    end
    repeat (2) step();
    reset_INV = 1'b1;
    repeat (4) step();
  endtask

  initial begin
    test_reset();
    test_stop();
    test_start_fail();
    test_lockout();
    test_timeout_and_stable();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d unmatched expected transitions, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
